// File: rtl/fir_mc_engine.sv
// Multi-channel time-multiplexed FIR engine: one multiply-accumulate per cycle over M taps,
// three programmable coefficient banks (LPF/HPF/BPF) and a bypass path.
module fir_mc_engine #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned M      = 23,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 16,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned TAP_W = $clog2(M),
  localparam int unsigned ACC_W = DATA_W + COEF_W + TAP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [1:0]        in_mode,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [DATA_W-1:0] out_data,
  input  logic              coef_we,
  input  logic [1:0]        coef_bank,
  input  logic [TAP_W-1:0]  coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              coef_err
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam logic [TAP_W-1:0] LastTap = TAP_W'(M - 1);
  // Truncates to 0 when M is a power of two; the modular index math below still holds.
  localparam logic [TAP_W-1:0] ModTap = TAP_W'(M);
  localparam logic [ACC_W:0] RndC = (ACC_W + 1)'(1) << (COEF_W - 2);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMac  = 2'd1,
    StOut  = 2'd2
  } state_t;

  state_t r_state, w_state_d;

  logic signed [DATA_W-1:0] r_hist [NUM_CH][M];
  logic signed [COEF_W-1:0] r_coef [3][M];
  logic [TAP_W-1:0]         r_wptr [NUM_CH];
  logic [TAP_W-1:0]         r_base;
  logic [TAP_W-1:0]         r_k;
  logic [CH_W-1:0]          r_ch;
  logic [1:0]               r_bank;
  logic signed [ACC_W-1:0]  r_acc;
  logic [CH_W-1:0]          r_out_ch;
  logic [DATA_W-1:0]        r_out_data;
  logic                     r_coef_err;

  logic                     w_accept;
  logic                     w_bypass;
  logic                     w_last;
  logic [CH_W-1:0]          w_ch;
  logic                     w_coef_ok;
  logic                     w_coef_rej;
  logic [TAP_W-1:0]         w_idx;
  logic signed [COEF_W-1:0] w_coef_x;
  logic signed [DATA_W-1:0] w_hist_x;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic [ACC_W:0]           w_rnd;
  logic signed [ACC_W:0]    w_shf;
  logic                     w_fits;
  logic [DATA_W-1:0]        w_sat;

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StOut);
  assign out_ch    = r_out_ch;
  assign out_data  = r_out_data;
  assign coef_err  = r_coef_err;

  assign w_accept = in_valid & in_ready;
  assign w_bypass = (in_mode == 2'b11);
  assign w_last   = (r_k == LastTap);
  // Out-of-range channel numbers alias onto channel 0.
  assign w_ch     = (32'(in_ch) < NUM_CH) ? in_ch : '0;

  assign w_coef_ok  = coef_we & in_ready & ~w_accept & (coef_bank != 2'd3) &
                      (32'(coef_addr) < M);
  assign w_coef_rej = coef_we & ~w_coef_ok;

  // r_base holds the slot of x[n]; x[n-k] lives k slots behind it, modulo M.
  assign w_idx    = (r_base >= r_k) ? (r_base - r_k) : (r_base + ModTap - r_k);
  assign w_coef_x = r_coef[r_bank][r_k];
  assign w_hist_x = r_hist[r_ch][w_idx];

  assign w_prod = $signed({{DATA_W{w_coef_x[COEF_W-1]}}, w_coef_x}) *
                  $signed({{COEF_W{w_hist_x[DATA_W-1]}}, w_hist_x});
  assign w_acc_next = r_acc + {{TAP_W{w_prod[PROD_W-1]}}, w_prod};

  assign w_rnd  = {w_acc_next[ACC_W-1], w_acc_next} + RndC;
  assign w_shf  = $signed(w_rnd) >>> (COEF_W - 1);
  assign w_fits = (&w_shf[ACC_W:DATA_W-1]) | ~(|w_shf[ACC_W:DATA_W-1]);
  assign w_sat  = w_fits      ? w_shf[DATA_W-1:0] :
                  w_shf[ACC_W] ? {1'b1, {(DATA_W-1){1'b0}}} :
                                 {1'b0, {(DATA_W-1){1'b1}}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_d = w_bypass ? StOut : StMac;
        end
      end
      StMac: begin
        if (w_last) begin
          w_state_d = StOut;
        end
      end
      StOut:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        r_wptr[c] <= '0;
        for (int t = 0; t < int'(M); t++) begin
          r_hist[c][t] <= '0;
        end
      end
      for (int b = 0; b < 3; b++) begin
        for (int t = 0; t < int'(M); t++) begin
          r_coef[b][t] <= '0;
        end
      end
      r_base     <= '0;
      r_k        <= '0;
      r_ch       <= '0;
      r_bank     <= '0;
      r_acc      <= '0;
      r_out_ch   <= '0;
      r_out_data <= '0;
      r_coef_err <= 1'b0;
    end else begin
      r_coef_err <= w_coef_rej;
      if (w_coef_ok) begin
        r_coef[coef_bank][coef_addr] <= coef_data;
      end

      if (w_accept) begin
        r_hist[w_ch][r_wptr[w_ch]] <= in_data;
        r_wptr[w_ch] <= (r_wptr[w_ch] == LastTap) ? '0 : r_wptr[w_ch] + 1'b1;
        r_base <= r_wptr[w_ch];
        r_ch   <= w_ch;
        r_bank <= in_mode;
        r_k    <= '0;
        r_acc  <= '0;
        if (w_bypass) begin
          r_out_data <= in_data;
          r_out_ch   <= w_ch;
        end
      end

      if (r_state == StMac) begin
        r_acc <= w_acc_next;
        r_k   <= r_k + 1'b1;
        if (w_last) begin
          r_out_data <= w_sat;
          r_out_ch   <= r_ch;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_mc_engine.sv
// Randomised and directed self-checking bench for fir_mc_engine (M=4, two channels),
// compared against a shift-register convolution model.
module tb_fir_mc_engine;

  localparam int NCH = 2;
  localparam int MT  = 4;
  localparam int DW  = 16;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [0:0]    in_ch = '0;
  logic [1:0]    in_mode = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic [0:0]    out_ch;
  logic [DW-1:0] out_data;
  logic          coef_we = 1'b0;
  logic [1:0]    coef_bank = '0;
  logic [1:0]    coef_addr = '0;
  logic [CW-1:0] coef_data = '0;
  logic          coef_err;

  always #5 clk = ~clk;

  fir_mc_engine #(
    .NUM_CH(NCH),
    .M     (MT),
    .DATA_W(DW),
    .COEF_W(CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ch    (in_ch),
    .in_mode  (in_mode),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ch   (out_ch),
    .out_data (out_data),
    .coef_we  (coef_we),
    .coef_bank(coef_bank),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .coef_err (coef_err)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Model: mh[c][k] is x[n-k] for channel c (newest first), mc[b][k] is tap k of bank b.
  int mc[3][MT];
  int mh[NCH][MT];

  function automatic void model_clear();
    for (int b = 0; b < 3; b++) for (int k = 0; k < MT; k++) mc[b][k] = 0;
    for (int c = 0; c < NCH; c++) for (int k = 0; k < MT; k++) mh[c][k] = 0;
  endfunction

  function automatic int model_step(int ch, int mode, int data);
    longint acc = 0;
    longint r;
    int c = (ch < NCH) ? ch : 0;
    for (int k = MT - 1; k > 0; k--) mh[c][k] = mh[c][k-1];
    mh[c][0] = data;
    if (mode == 3) return data;
    for (int k = 0; k < MT; k++) acc += longint'(mc[mode][k]) * longint'(mh[c][k]);
    r = (acc + 64'sd16384) >>> 15;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    coef_we = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic write_coef(input int bank, input int addr, input int val);
    @(negedge clk);
    coef_we = 1'b1;
    coef_bank = 2'(bank);
    coef_addr = 2'(addr);
    coef_data = 16'(val);
    @(negedge clk);
    coef_we = 1'b0;
    if (bank < 3 && addr < MT) mc[bank][addr] = int'($signed(16'(val)));
  endtask

  task automatic load_impulse_bank();
    write_coef(0, 0, 16'h4000);
    write_coef(0, 1, 16'h2000);
    write_coef(0, 2, 16'h1000);
    write_coef(0, 3, 16'h0800);
  endtask

  // Offers one sample (optionally with a coefficient write in the same cycle); returns at
  // the first falling edge after the accept edge.
  task automatic start(input int ch, input int mode, input int data, input bit cw);
    int guard = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1;
    in_ch = 1'(ch);
    in_mode = 2'(mode);
    in_data = 16'(data);
    coef_we = cw;
    @(negedge clk);
    in_valid = 1'b0;
    coef_we = 1'b0;
  endtask

  task automatic finish_out(input int lat0, output int lat, output int od, output int och);
    lat = lat0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    od = int'($signed(out_data));
    och = int'(out_ch);
  endtask

  task automatic test_reset();
    do_reset();
    n_total += 5;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else n_pass++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
    else n_pass++;
    if (out_data !== 16'd0) $display("FAIL reset_out_data: got %0d want 0", out_data);
    else n_pass++;
    if (out_ch !== 1'b0) $display("FAIL reset_out_ch: got %0d want 0", out_ch);
    else n_pass++;
    if (coef_err !== 1'b0) $display("FAIL reset_coef_err: got %b want 0", coef_err);
    else n_pass++;
  endtask

  task automatic test_impulse();
    int seq[5] = '{16384, 0, 0, 0, 0};
    int exp_o[5] = '{8192, 4096, 2048, 1024, 0};
    int lat, od, och;
    do_reset();
    load_impulse_bank();
    for (int i = 0; i < 5; i++) begin
      start(0, 0, seq[i], 1'b0);
      finish_out(1, lat, od, och);
      void'(model_step(0, 0, seq[i]));
      n_total += 3;
      if (lat != MT + 1) $display("FAIL impulse_lat[%0d]: got %0d want %0d", i, lat, MT + 1);
      else n_pass++;
      if (od != exp_o[i]) $display("FAIL impulse_out[%0d]: got %0d want %0d", i, od, exp_o[i]);
      else n_pass++;
      if (och != 0) $display("FAIL impulse_ch[%0d]: got %0d want 0", i, och);
      else n_pass++;
    end
  endtask

  task automatic test_interleave();
    int seq[5] = '{16384, 0, 0, 0, 0};
    int exp_o[5] = '{8192, 4096, 2048, 1024, 0};
    int lat, od, och;
    do_reset();
    load_impulse_bank();
    for (int i = 0; i < 5; i++) begin
      start(0, 0, seq[i], 1'b0);
      finish_out(1, lat, od, och);
      n_total++;
      if (od != exp_o[i]) $display("FAIL ileave_ch0[%0d]: got %0d want %0d", i, od, exp_o[i]);
      else n_pass++;
      start(1, 0, 0, 1'b0);
      finish_out(1, lat, od, och);
      n_total += 2;
      if (od != 0) $display("FAIL ileave_ch1[%0d]: got %0d want 0", i, od);
      else n_pass++;
      if (och != 1) $display("FAIL ileave_ch1_tag[%0d]: got %0d want 1", i, och);
      else n_pass++;
    end
  endtask

  task automatic test_saturate();
    int lat, od, och, e;
    do_reset();
    for (int k = 0; k < MT; k++) write_coef(0, k, 16'h7FFF);
    for (int i = 0; i < 2 * MT; i++) begin
      int d = (i < MT) ? 32767 : -32768;
      start(0, 0, d, 1'b0);
      finish_out(1, lat, od, och);
      e = model_step(0, 0, d);
      n_total++;
      if (od != e) $display("FAIL sat_model[%0d]: got %0d want %0d", i, od, e);
      else n_pass++;
      if (i == MT - 1 || i == 2 * MT - 1) begin
        e = (i == MT - 1) ? 32767 : -32768;
        n_total++;
        if (od != e) $display("FAIL sat_limit[%0d]: got %0d want %0d", i, od, e);
        else n_pass++;
      end
    end
  endtask

  task automatic test_bypass();
    int lat, od, och, e;
    do_reset();
    load_impulse_bank();
    start(1, 3, -1234, 1'b0);
    finish_out(1, lat, od, och);
    e = model_step(1, 3, -1234);
    n_total += 3;
    if (lat != 1) $display("FAIL bypass_lat: got %0d want 1", lat);
    else n_pass++;
    if (od != e) $display("FAIL bypass_out: got %0d want %0d", od, e);
    else n_pass++;
    if (och != 1) $display("FAIL bypass_ch: got %0d want 1", och);
    else n_pass++;
    @(negedge clk);
    n_total += 2;
    if (out_valid !== 1'b0) $display("FAIL bypass_pulse: got %b want 0", out_valid);
    else n_pass++;
    if ($signed(out_data) != -1234) $display("FAIL bypass_hold: got %0d want -1234", $signed(out_data));
    else n_pass++;
    start(1, 0, 0, 1'b0);
    finish_out(1, lat, od, och);
    e = model_step(1, 0, 0);
    n_total++;
    if (od != e) $display("FAIL bypass_history: got %0d want %0d", od, e);
    else n_pass++;
  endtask

  task automatic test_coef_err();
    int lat, od, och, e;
    do_reset();
    load_impulse_bank();
    start(0, 0, 16384, 1'b0);
    coef_we = 1'b1;
    coef_bank = 2'd0;
    coef_addr = 2'd0;
    coef_data = 16'h1234;
    @(negedge clk);
    coef_we = 1'b0;
    n_total++;
    if (coef_err !== 1'b1) $display("FAIL err_mac_pulse: got %b want 1", coef_err);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (coef_err !== 1'b0) $display("FAIL err_mac_once: got %b want 0", coef_err);
    else n_pass++;
    finish_out(3, lat, od, och);
    e = model_step(0, 0, 16384);
    n_total += 2;
    if (lat != MT + 1) $display("FAIL err_mac_lat: got %0d want %0d", lat, MT + 1);
    else n_pass++;
    if (od != e) $display("FAIL err_mac_old_coef: got %0d want %0d", od, e);
    else n_pass++;

    coef_bank = 2'd0;
    coef_addr = 2'd1;
    coef_data = 16'h0000;
    start(0, 0, 0, 1'b1);
    n_total++;
    if (coef_err !== 1'b1) $display("FAIL err_accept_pulse: got %b want 1", coef_err);
    else n_pass++;
    finish_out(1, lat, od, och);
    e = model_step(0, 0, 0);
    n_total++;
    if (od != e) $display("FAIL err_accept_coef: got %0d want %0d", od, e);
    else n_pass++;

    @(negedge clk);
    coef_we = 1'b1;
    coef_bank = 2'd3;
    coef_addr = 2'd0;
    coef_data = 16'h7FFF;
    @(negedge clk);
    coef_we = 1'b0;
    n_total++;
    if (coef_err !== 1'b1) $display("FAIL err_bank3: got %b want 1", coef_err);
    else n_pass++;

    @(negedge clk);
    coef_we = 1'b1;
    coef_bank = 2'd0;
    coef_addr = 2'd3;
    coef_data = 16'h0400;
    @(negedge clk);
    coef_we = 1'b0;
    mc[0][3] = 16'h0400;
    n_total++;
    if (coef_err !== 1'b0) $display("FAIL err_idle_write: got %b want 0", coef_err);
    else n_pass++;
    start(0, 0, 0, 1'b0);
    finish_out(1, lat, od, och);
    e = model_step(0, 0, 0);
    n_total++;
    if (od != e) $display("FAIL err_bank3_nowrite: got %0d want %0d", od, e);
    else n_pass++;
    start(0, 0, 0, 1'b0);
    finish_out(1, lat, od, och);
    e = model_step(0, 0, 0);
    n_total++;
    if (od != e) $display("FAIL err_idle_written: got %0d want %0d", od, e);
    else n_pass++;
  endtask

  task automatic test_reset_mid_mac();
    int seq[4] = '{16384, 0, 0, 0};
    int exp_o[4] = '{8192, 4096, 2048, 1024};
    int lat, od, och;
    bit saw_valid = 1'b0;
    do_reset();
    load_impulse_bank();
    start(0, 0, 12345, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 8; i++) begin
      if (out_valid === 1'b1) saw_valid = 1'b1;
      @(negedge clk);
    end
    n_total += 2;
    if (saw_valid) $display("FAIL abort_no_valid: got 1 want 0");
    else n_pass++;
    if (in_ready !== 1'b1) $display("FAIL abort_ready: got %b want 1", in_ready);
    else n_pass++;
    load_impulse_bank();
    for (int i = 0; i < 4; i++) begin
      start(0, 0, seq[i], 1'b0);
      finish_out(1, lat, od, och);
      n_total++;
      if (od != exp_o[i]) $display("FAIL abort_replay[%0d]: got %0d want %0d", i, od, exp_o[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int lat, od, och, e, ch, mode, d;
    do_reset();
    for (int b = 0; b < 3; b++)
      for (int k = 0; k < MT; k++) write_coef(b, k, int'($urandom_range(0, 65535)) - 32768);
    for (int i = 0; i < 40; i++) begin
      ch = int'($urandom_range(0, NCH - 1));
      mode = int'($urandom_range(0, 3));
      d = (i % 3 == 0) ? int'($urandom_range(0, 511)) - 256 : int'($urandom_range(0, 65535)) - 32768;
      start(ch, mode, d, 1'b0);
      finish_out(1, lat, od, och);
      e = model_step(ch, mode, d);
      n_total += 3;
      if (lat != ((mode == 3) ? 1 : MT + 1))
        $display("FAIL rand_lat[%0d]: got %0d want %0d", i, lat, (mode == 3) ? 1 : MT + 1);
      else n_pass++;
      if (od != e) $display("FAIL rand_out[%0d]: got %0d want %0d (mode %0d)", i, od, e, mode);
      else n_pass++;
      if (och != ch) $display("FAIL rand_ch[%0d]: got %0d want %0d", i, och, ch);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_interleave();
    test_saturate();
    test_bypass();
    test_coef_err();
    test_reset_mid_mac();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
